// File: rtl/lfo_multi.sv
// Multi-channel low-frequency control-word generator: per-channel prescaler
// gated by the shared 3 MHz enable, driving ramp, triangle, sawtooth or slew updates.
module lfo_multi #(
  parameter int WIDTH         = 8,
  parameter int CHANNELS      = 2,
  parameter int PRESCALE_BITS = 14
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clk_3MHz_en,
  input  logic [CHANNELS-1:0]               dir,
  input  logic [2*CHANNELS-1:0]             mode,
  input  logic [PRESCALE_BITS*CHANNELS-1:0] period,
  input  logic [WIDTH*CHANNELS-1:0]         step,
  input  logic [WIDTH*CHANNELS-1:0]         target,
  output logic [WIDTH*CHANNELS-1:0]         out,
  output logic [CHANNELS-1:0]               tick,
  output logic [CHANNELS-1:0]               at_limit
);

  localparam logic [1:0] MODE_RAMP = 2'd0;
  localparam logic [1:0] MODE_TRI  = 2'd1;
  localparam logic [1:0] MODE_SAW  = 2'd2;
  localparam logic [1:0] MODE_SLEW = 2'd3;

  localparam logic [WIDTH-1:0]         OUT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH:0]           MAX_W   = {1'b0, {WIDTH{1'b1}}};
  localparam logic [PRESCALE_BITS-1:0] CNT_ONE = {{(PRESCALE_BITS-1){1'b0}}, 1'b1};

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [PRESCALE_BITS-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]         out_q, out_d;
    logic                     tick_q, tick_d;
    logic                     lim_q, lim_d;
    logic                     down_q, down_d;

    logic [PRESCALE_BITS-1:0] per_c;
    logic [WIDTH-1:0]         step_c;
    logic [WIDTH-1:0]         tgt_c;
    logic [1:0]               mode_c;
    logic                     dir_c;

    logic                     fire;
    logic [WIDTH:0]           sum;
    logic [WIDTH:0]           diff;
    logic [WIDTH:0]           gap;
    logic                     tgt_above;

    assign per_c  = period[c*PRESCALE_BITS +: PRESCALE_BITS];
    assign step_c = step[c*WIDTH +: WIDTH];
    assign tgt_c  = target[c*WIDTH +: WIDTH];
    assign mode_c = mode[2*c +: 2];
    assign dir_c  = dir[c];

    // Arithmetic is one bit wider so carry/borrow mark rail crossings and wraps.
    always_comb begin
      fire      = clk_3MHz_en && (cnt_q == '0);
      sum       = {1'b0, out_q} + {1'b0, step_c};
      diff      = {1'b0, out_q} - {1'b0, step_c};
      tgt_above = (tgt_c >= out_q);
      gap       = tgt_above ? ({1'b0, tgt_c} - {1'b0, out_q})
                            : ({1'b0, out_q} - {1'b0, tgt_c});
    end

    always_comb begin
      cnt_d  = cnt_q;
      out_d  = out_q;
      lim_d  = lim_q;
      down_d = down_q;
      tick_d = 1'b0;

      // A period lowered below the running count wraps to zero on the next enable.
      if (clk_3MHz_en) begin
        cnt_d = (cnt_q >= per_c) ? '0 : cnt_q + CNT_ONE;
      end

      if (fire) begin
        tick_d = 1'b1;
        case (mode_c)
          MODE_RAMP: begin
            if (!dir_c) begin
              out_d = (sum > MAX_W) ? OUT_MAX : sum[WIDTH-1:0];
            end else begin
              out_d = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
            end
            lim_d = (out_d == '0) || (out_d == OUT_MAX);
          end
          MODE_TRI: begin
            if (!down_q) begin
              if (sum >= MAX_W) begin
                out_d  = OUT_MAX;
                down_d = 1'b1;
              end else begin
                out_d = sum[WIDTH-1:0];
              end
            end else begin
              if (out_q <= step_c) begin
                out_d  = '0;
                down_d = 1'b0;
              end else begin
                out_d = diff[WIDTH-1:0];
              end
            end
            lim_d = (out_d == '0) || (out_d == OUT_MAX);
          end
          MODE_SAW: begin
            if (!dir_c) begin
              out_d = sum[WIDTH-1:0];
              lim_d = sum[WIDTH];
            end else begin
              out_d = diff[WIDTH-1:0];
              lim_d = diff[WIDTH];
            end
          end
          MODE_SLEW: begin
            if (gap <= {1'b0, step_c}) begin
              out_d = tgt_c;
            end else if (tgt_above) begin
              out_d = sum[WIDTH-1:0];
            end else begin
              out_d = diff[WIDTH-1:0];
            end
            lim_d = (out_d == tgt_c);
          end
          default: begin
            out_d = out_q;
          end
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q  <= '0;
        out_q  <= '0;
        tick_q <= 1'b0;
        lim_q  <= 1'b0;
        down_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        out_q  <= out_d;
        tick_q <= tick_d;
        lim_q  <= lim_d;
        down_q <= down_d;
      end
    end

    assign out[c*WIDTH +: WIDTH] = out_q;
    assign tick[c]               = tick_q;
    assign at_limit[c]           = lim_q;
  end

endmodule

// File: tb/tb_lfo_multi.sv
// Bench for lfo_multi: scenario tasks push expected {out, at_limit} pairs and
// pop them as the channel under test ticks.
module tb_lfo_multi;
  localparam int W  = 8;
  localparam int CH = 2;
  localparam int PB = 14;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              clk_3MHz_en = 1'b0;
  logic [CH-1:0]     dir = '0;
  logic [2*CH-1:0]   mode = '0;
  logic [PB*CH-1:0]  period = '0;
  logic [W*CH-1:0]   step = '0;
  logic [W*CH-1:0]   target = '0;
  logic [W*CH-1:0]   out;
  logic [CH-1:0]     tick;
  logic [CH-1:0]     at_limit;

  logic [W:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  lfo_multi #(.WIDTH(W), .CHANNELS(CH), .PRESCALE_BITS(PB)) dut (
    .clk(clk), .rst(rst), .clk_3MHz_en(clk_3MHz_en), .dir(dir), .mode(mode),
    .period(period), .step(step), .target(target), .out(out), .tick(tick),
    .at_limit(at_limit)
  );

  always #5 clk = ~clk;

  // One clock with the given enable; outputs are sampled 1 ns after the edge.
  task automatic step_cycle(input logic en);
    clk_3MHz_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    dir = '0; mode = '0; period = '0; step = '0; target = '0;
    rst = 1'b1;
    step_cycle(1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step_cycle(1'b1);
    step_cycle(1'b1);
    n_checks++; if (out !== '0) begin n_fail++; $display("FAIL reset_out got %h want 0", out); end
    n_checks++; if (tick !== '0) begin n_fail++; $display("FAIL reset_tick got %b want 0", tick); end
    n_checks++; if (at_limit !== '0) begin n_fail++; $display("FAIL reset_limit got %b want 0", at_limit); end
    rst = 1'b0;
  endtask

  task automatic test_ramp;
    logic [W:0] exp;
    int clk_n, prev;
    do_reset();
    mode[1:0] = 2'd0; period[PB-1:0] = 14'd3; step[W-1:0] = 8'd1; dir[0] = 1'b0;
    for (int k = 1; k <= 255; k++) exp_q.push_back({8'(k), 1'(k == 255)});
    exp_q.push_back({8'd255, 1'b1});
    exp_q.push_back({8'd255, 1'b1});
    clk_n = 0; prev = -1;
    for (int ph = 0; ph < 2; ph++) begin
      while (exp_q.size() > 0 && clk_n < 20000) begin
        step_cycle(clk_n % 4 == 0);
        clk_n++;
        if (tick[0]) begin
          exp = exp_q.pop_front();
          n_checks++;
          if ({out[W-1:0], at_limit[0]} !== exp) begin
            n_fail++; $display("FAIL ramp ph%0d got out=%0d lim=%b want out=%0d lim=%b",
                                ph, out[W-1:0], at_limit[0], exp[W:1], exp[0]);
          end
          if (prev >= 0) begin
            n_checks++;
            if (clk_n - prev != 16) begin n_fail++; $display("FAIL ramp_spacing got %0d want 16", clk_n - prev); end
          end
          prev = clk_n;
        end
      end
      if (exp_q.size() != 0) begin
        n_checks++; n_fail++; $display("FAIL ramp_timeout ph%0d left %0d want 0", ph, exp_q.size());
        exp_q.delete();
      end
      if (ph == 0) begin
        dir[0] = 1'b1;
        for (int k = 254; k >= 0; k--) exp_q.push_back({8'(k), 1'(k == 0)});
        exp_q.push_back({8'd0, 1'b1});
        exp_q.push_back({8'd0, 1'b1});
      end
    end
  endtask

  task automatic test_triangle;
    logic [W:0] exp;
    int clk_n;
    do_reset();
    mode[1:0] = 2'd1; period[PB-1:0] = '0; step[W-1:0] = 8'd100; dir[0] = 1'b1;
    exp_q.push_back({8'd100, 1'b0}); exp_q.push_back({8'd200, 1'b0});
    exp_q.push_back({8'd255, 1'b1}); exp_q.push_back({8'd155, 1'b0});
    exp_q.push_back({8'd55, 1'b0});  exp_q.push_back({8'd0, 1'b1});
    exp_q.push_back({8'd100, 1'b0});
    clk_n = 0;
    while (exp_q.size() > 0 && clk_n < 50) begin
      step_cycle(1'b1);
      clk_n++;
      if (tick[0]) begin
        exp = exp_q.pop_front();
        n_checks++;
        if ({out[W-1:0], at_limit[0]} !== exp) begin
          n_fail++; $display("FAIL triangle got out=%0d lim=%b want out=%0d lim=%b",
                              out[W-1:0], at_limit[0], exp[W:1], exp[0]);
        end
      end
    end
    if (exp_q.size() != 0) begin
      n_checks++; n_fail++; $display("FAIL triangle_timeout left %0d want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_sawtooth;
    logic [W:0] exp;
    int clk_n;
    do_reset();
    mode[1:0] = 2'd2; period[PB-1:0] = '0; step[W-1:0] = 8'd100; dir[0] = 1'b0;
    exp_q.push_back({8'd100, 1'b0}); exp_q.push_back({8'd200, 1'b0});
    exp_q.push_back({8'd44, 1'b1});
    for (int ph = 0; ph < 2; ph++) begin
      clk_n = 0;
      while (exp_q.size() > 0 && clk_n < 50) begin
        step_cycle(1'b1);
        clk_n++;
        if (tick[0]) begin
          exp = exp_q.pop_front();
          n_checks++;
          if ({out[W-1:0], at_limit[0]} !== exp) begin
            n_fail++; $display("FAIL saw ph%0d got out=%0d lim=%b want out=%0d lim=%b",
                                ph, out[W-1:0], at_limit[0], exp[W:1], exp[0]);
          end
        end
      end
      if (exp_q.size() != 0) begin
        n_checks++; n_fail++; $display("FAIL saw_timeout ph%0d left %0d want 0", ph, exp_q.size());
        exp_q.delete();
      end
      dir[0] = 1'b1;
      if (ph == 0) exp_q.push_back({8'd200, 1'b1});
    end
  endtask

  task automatic test_slew;
    logic [W:0] exp;
    int clk_n;
    do_reset();
    mode[1:0] = 2'd3; period[PB-1:0] = 14'd1; step[W-1:0] = 8'd20; target[W-1:0] = 8'd50;
    exp_q.push_back({8'd20, 1'b0}); exp_q.push_back({8'd40, 1'b0});
    exp_q.push_back({8'd50, 1'b1}); exp_q.push_back({8'd50, 1'b1});
    for (int ph = 0; ph < 2; ph++) begin
      clk_n = 0;
      while (exp_q.size() > 0 && clk_n < 50) begin
        step_cycle(1'b1);
        clk_n++;
        if (tick[0]) begin
          exp = exp_q.pop_front();
          n_checks++;
          if ({out[W-1:0], at_limit[0]} !== exp) begin
            n_fail++; $display("FAIL slew ph%0d got out=%0d lim=%b want out=%0d lim=%b",
                                ph, out[W-1:0], at_limit[0], exp[W:1], exp[0]);
          end
        end
      end
      if (exp_q.size() != 0) begin
        n_checks++; n_fail++; $display("FAIL slew_timeout ph%0d left %0d want 0", ph, exp_q.size());
        exp_q.delete();
      end
      target[W-1:0] = 8'd10;
      if (ph == 0) begin
        exp_q.push_back({8'd30, 1'b0}); exp_q.push_back({8'd10, 1'b1});
      end
    end
  endtask

  task automatic test_step_zero;
    do_reset();
    mode[1:0] = 2'd0; step[W-1:0] = '0;
    step_cycle(1'b1);
    n_checks++;
    if ({tick[0], out[W-1:0], at_limit[0]} !== {1'b1, 8'd0, 1'b1}) begin
      n_fail++; $display("FAIL step_zero got tick=%b out=%0d lim=%b want tick=1 out=0 lim=1",
                          tick[0], out[W-1:0], at_limit[0]);
    end
    step_cycle(1'b0);
    n_checks++;
    if (tick[0] !== 1'b0) begin n_fail++; $display("FAIL tick_width got %b want 0", tick[0]); end
  endtask

  task automatic test_independence;
    int t0, t1;
    do_reset();
    mode = '0; step[W-1:0] = '0; step[2*W-1:W] = 8'd1;
    period[PB-1:0] = 14'd1; period[2*PB-1:PB] = 14'd4;
    t0 = 0; t1 = 0;
    for (int i = 0; i < 10; i++) begin
      step_cycle(1'b1);
      if (tick[0]) t0++;
      if (tick[1]) t1++;
    end
    n_checks++; if (t0 != 5) begin n_fail++; $display("FAIL ch0_ticks got %0d want 5", t0); end
    n_checks++; if (t1 != 2) begin n_fail++; $display("FAIL ch1_ticks got %0d want 2", t1); end
    for (int i = 0; i < 3; i++) step_cycle(1'b1);
    period[2*PB-1:PB] = '0;
    step_cycle(1'b1);
    n_checks++; if (tick[1] !== 1'b0) begin n_fail++; $display("FAIL period_wrap got tick=%b want 0", tick[1]); end
    step_cycle(1'b1);
    n_checks++;
    if ({tick[1], out[2*W-1:W], at_limit[1]} !== {1'b1, 8'd4, 1'b0}) begin
      n_fail++; $display("FAIL period_fire got tick=%b out=%0d lim=%b want tick=1 out=4 lim=0",
                          tick[1], out[2*W-1:W], at_limit[1]);
    end
  endtask

  task automatic test_reset_midop;
    logic [W:0] exp;
    int clk_n;
    do_reset();
    mode[1:0] = 2'd1; period[PB-1:0] = 14'd2; step[W-1:0] = 8'd55;
    exp_q.push_back({8'd55, 1'b0});  exp_q.push_back({8'd110, 1'b0});
    exp_q.push_back({8'd165, 1'b0}); exp_q.push_back({8'd220, 1'b0});
    exp_q.push_back({8'd255, 1'b1}); exp_q.push_back({8'd200, 1'b0});
    clk_n = 0;
    while (exp_q.size() > 0 && clk_n < 60) begin
      step_cycle(1'b1);
      clk_n++;
      if (tick[0]) begin
        exp = exp_q.pop_front();
        n_checks++;
        if ({out[W-1:0], at_limit[0]} !== exp) begin
          n_fail++; $display("FAIL midop_pre got out=%0d lim=%b want out=%0d lim=%b",
                              out[W-1:0], at_limit[0], exp[W:1], exp[0]);
        end
      end
    end
    if (exp_q.size() != 0) begin
      n_checks++; n_fail++; $display("FAIL midop_timeout left %0d want 0", exp_q.size());
      exp_q.delete();
    end
    step_cycle(1'b1);
    rst = 1'b1;
    step_cycle(1'b1);
    n_checks++;
    if ({tick[0], out[W-1:0], at_limit[0]} !== {1'b0, 8'd0, 1'b0}) begin
      n_fail++; $display("FAIL midop_reset got tick=%b out=%0d lim=%b want tick=0 out=0 lim=0",
                          tick[0], out[W-1:0], at_limit[0]);
    end
    rst = 1'b0;
    step_cycle(1'b1);
    n_checks++;
    if ({tick[0], out[W-1:0], at_limit[0]} !== {1'b1, 8'd55, 1'b0}) begin
      n_fail++; $display("FAIL midop_restart got tick=%b out=%0d lim=%b want tick=1 out=55 lim=0",
                          tick[0], out[W-1:0], at_limit[0]);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_triangle();
    test_sawtooth();
    test_slew();
    test_step_zero();
    test_independence();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
